life_engine: RTL

LIFE_ENGINE -- requirements
Module: life_engine

---
 rtl/life_pkg.sv | 31 +++
 rtl/life_row.sv | 32 +++
 rtl/life_engine.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared types and cell-rule constants for the Game of Life engine.
package life_pkg;

  // Run sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // A live cell with exactly this many live neighbours keeps its state.
  localparam logic [3:0] SURVIVE_COUNT = 4'd2;
  // Exactly this many live neighbours makes a cell alive.
  localparam logic [3:0] BIRTH_COUNT   = 4'd3;

  // Population count of the eight neighbours of one cell.
  function automatic logic [3:0] neighbour_sum(input logic [7:0] nbrs);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'b000, nbrs[i]};
    end
    return sum;
  endfunction

  // Next state of one cell given its current state and neighbour sum.
  function automatic logic cell_next(input logic alive, input logic [3:0] sum);
    return (sum == BIRTH_COUNT) || (alive && (sum == SURVIVE_COUNT));
  endfunction

endpackage

// File: rtl/life_row.sv
// Combinational next-generation computation for one grid row.
module life_row
  import life_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WRAP  = 1
) (
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] below,
  output logic [WIDTH-1:0] next
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_col
      // Edge columns either wrap to the far side or see a dead neighbour.
      localparam int LEFT     = (gi == 0) ? WIDTH - 1 : gi - 1;
      localparam int RIGHT    = (gi == WIDTH - 1) ? 0 : gi + 1;
      localparam bit LEFT_OK  = (gi != 0) || (WRAP != 0);
      localparam bit RIGHT_OK = (gi != WIDTH - 1) || (WRAP != 0);

      logic [7:0] nbrs;

      assign nbrs = {LEFT_OK & above[LEFT], above[gi], RIGHT_OK & above[RIGHT],
                     LEFT_OK & cur[LEFT],              RIGHT_OK & cur[RIGHT],
                     LEFT_OK & below[LEFT], below[gi], RIGHT_OK & below[RIGHT]};
      assign next[gi] = cell_next(cur[gi], neighbour_sum(nbrs));
    end
  endgenerate

endmodule

// File: rtl/life_engine.sv
// Game of Life engine: loads a grid, runs N generations row by row into a
// shadow grid, and commits each finished generation in a single cycle.
module life_engine
  import life_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int WRAP   = 1,
  parameter int GEN_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [$clog2(HEIGHT)-1:0] load_row,
  input  logic [WIDTH-1:0]          load_data,
  input  logic                      start,
  input  logic [GEN_W-1:0]          gens,
  input  logic                      stop_on_stable,
  output logic                      busy,
  output logic                      done,
  output logic [GEN_W-1:0]          gen_count,
  output logic                      stable,
  output logic                      extinct,
  input  logic [$clog2(HEIGHT)-1:0] rd_row,
  output logic [WIDTH-1:0]          rd_data
);

  localparam int               ROW_W    = $clog2(HEIGHT);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [GEN_W-1:0] GEN_ONE  = GEN_W'(1);

  state_t            state_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [WIDTH-1:0]  grid_reg   [HEIGHT];
  logic [WIDTH-1:0]  shadow_reg [HEIGHT];
  logic [GEN_W-1:0]  gen_count_reg;
  logic [GEN_W-1:0]  gens_reg;
  logic [GEN_W-1:0]  gen_next;
  logic              sos_reg;
  logic              stable_reg;
  logic              done_reg;
  logic [WIDTH-1:0]  rd_data_reg;
  logic [WIDTH-1:0]  above_row;
  logic [WIDTH-1:0]  cur_row;
  logic [WIDTH-1:0]  below_row;
  logic [WIDTH-1:0]  next_row;
  logic [HEIGHT-1:0] row_diff;
  logic [HEIGHT-1:0] row_live;
  logic              no_change;

  // Per-row change and liveness flags for stability and extinction.
  genvar gi;
  generate
    for (gi = 0; gi < HEIGHT; gi++) begin : g_row_flags
      assign row_diff[gi] = |(grid_reg[gi] ^ shadow_reg[gi]);
      assign row_live[gi] = |grid_reg[gi];
    end
  endgenerate

  assign no_change = ~|row_diff;

  // Fetch the committed rows around the row being computed.
  always_comb begin
    cur_row   = grid_reg[row_reg];
    above_row = '0;
    below_row = '0;
    if (row_reg != '0) begin
      above_row = grid_reg[row_reg - ROW_ONE];
    end else if (WRAP != 0) begin
      above_row = grid_reg[LAST_ROW];
    end
    if (row_reg != LAST_ROW) begin
      below_row = grid_reg[row_reg + ROW_ONE];
    end else if (WRAP != 0) begin
      below_row = grid_reg[0];
    end
  end

  life_row #(
    .WIDTH(WIDTH),
    .WRAP (WRAP)
  ) u_row (
    .above(above_row),
    .cur  (cur_row),
    .below(below_row),
    .next (next_row)
  );

  // Generation counter sticks at all-ones instead of wrapping.
  assign gen_next = (&gen_count_reg) ? gen_count_reg : gen_count_reg + GEN_ONE;

  // Sequencer, grid storage and registered readout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      row_reg       <= '0;
      gen_count_reg <= '0;
      gens_reg      <= '0;
      sos_reg       <= 1'b0;
      stable_reg    <= 1'b0;
      done_reg      <= 1'b0;
      rd_data_reg   <= '0;
      for (int i = 0; i < HEIGHT; i++) begin
        grid_reg[i]   <= '0;
        shadow_reg[i] <= '0;
      end
    end else begin
      done_reg    <= 1'b0;
      rd_data_reg <= (int'(rd_row) < HEIGHT) ? grid_reg[rd_row] : '0;
      case (state_reg)
        ST_IDLE: begin
          if (load_valid && (int'(load_row) < HEIGHT)) begin
            grid_reg[load_row] <= load_data;
          end
          if (start) begin
            gen_count_reg <= '0;
            if (gens == '0) begin
              done_reg <= 1'b1;
            end else begin
              gens_reg  <= gens;
              sos_reg   <= stop_on_stable;
              row_reg   <= '0;
              state_reg <= ST_STEP;
            end
          end
        end
        ST_STEP: begin
          shadow_reg[row_reg] <= next_row;
          if (row_reg == LAST_ROW) begin
            state_reg <= ST_COMMIT;
          end else begin
            row_reg <= row_reg + ROW_ONE;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < HEIGHT; i++) begin
            grid_reg[i] <= shadow_reg[i];
          end
          gen_count_reg <= gen_next;
          stable_reg    <= no_change;
          if ((gen_next == gens_reg) || (sos_reg && no_change)) begin
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            row_reg   <= '0;
            state_reg <= ST_STEP;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign load_ready = (state_reg == ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign done       = done_reg;
  assign gen_count  = gen_count_reg;
  assign stable     = stable_reg;
  assign extinct    = ~|row_live;
  assign rd_data    = rd_data_reg;

endmodule
